// File: rtl/bram_arbiter.sv
// Arbiter sharing one single-port BRAM between instruction fetch and the load/store unit.
// Define BRAM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module bram_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  function automatic logic out_of_range(input logic [AW-1:0] addr);
    return |addr[AW-1:DEPTH];
  endfunction

  state_t        r_state, w_state_nxt;
  logic          r_win_d, w_win_d_nxt;
  logic          r_we,    w_we_nxt;
  logic          r_oor,   w_oor_nxt;

  logic          r_i_gnt,    w_i_gnt;
  logic          r_i_rvalid, w_i_rvalid;
  logic [DW-1:0] r_i_rdata,  w_i_rdata;
  logic          r_i_err,    w_i_err;
  logic          r_d_gnt,    w_d_gnt;
  logic          r_d_rvalid, w_d_rvalid;
  logic [DW-1:0] r_d_rdata,  w_d_rdata;
  logic          r_d_err,    w_d_err;
  logic          r_mem_rd_en, w_mem_rd_en;
  logic          r_mem_wr_en, w_mem_wr_en;
  logic [AW-1:0] r_mem_addr,  w_mem_addr;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata;

  logic          w_pick_d;
  logic [AW-1:0] w_sel_addr;
  logic          w_sel_we;
  logic          w_sel_oor;

`ifdef BRAM_ARB_RR_EN
  // 1 = fetch is favoured on the next tie; reset favours data.
  logic          r_fav_i, w_fav_i_nxt;

  always_comb begin
    w_pick_d = d_req && !(i_req && r_fav_i);
  end
`else
  always_comb begin
    w_pick_d = d_req;
  end
`endif

  always_comb begin
    w_sel_addr = w_pick_d ? d_addr : i_addr;
    w_sel_we   = w_pick_d && d_we;
    w_sel_oor  = out_of_range(w_sel_addr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_win_d_nxt = r_win_d;
    w_we_nxt    = r_we;
    w_oor_nxt   = r_oor;
    w_i_gnt     = 1'b0;
    w_i_rvalid  = 1'b0;
    w_i_rdata   = r_i_rdata;
    w_i_err     = 1'b0;
    w_d_gnt     = 1'b0;
    w_d_rvalid  = 1'b0;
    w_d_rdata   = r_d_rdata;
    w_d_err     = 1'b0;
    w_mem_rd_en = 1'b0;
    w_mem_wr_en = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
`ifdef BRAM_ARB_RR_EN
    w_fav_i_nxt = r_fav_i;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_state_nxt = S_ISSUE;
          w_win_d_nxt = w_pick_d;
          w_we_nxt    = w_sel_we;
          w_oor_nxt   = w_sel_oor;
          w_d_gnt     = w_pick_d;
          w_i_gnt     = !w_pick_d;
          w_d_err     = w_sel_we && w_sel_oor;
          w_mem_addr  = w_sel_addr;
          if (w_sel_we) begin
            w_mem_wdata = d_wdata;
          end
          w_mem_rd_en = !w_sel_we && !w_sel_oor;
          w_mem_wr_en = w_sel_we && !w_sel_oor;
`ifdef BRAM_ARB_RR_EN
          w_fav_i_nxt = w_pick_d;
`endif
        end
      end
      S_ISSUE: begin
        w_state_nxt = r_we ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        // RAM data for the read issued last cycle is on mem_rdata now.
        w_state_nxt = S_IDLE;
        if (r_win_d) begin
          w_d_rvalid = 1'b1;
          w_d_err    = r_oor;
          w_d_rdata  = r_oor ? '0 : mem_rdata;
        end else begin
          w_i_rvalid = 1'b1;
          w_i_err    = r_oor;
          w_i_rdata  = r_oor ? '0 : mem_rdata;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_d     <= 1'b0;
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_i_gnt     <= 1'b0;
      r_i_rvalid  <= 1'b0;
      r_i_rdata   <= '0;
      r_i_err     <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_win_d     <= w_win_d_nxt;
      r_we        <= w_we_nxt;
      r_oor       <= w_oor_nxt;
      r_i_gnt     <= w_i_gnt;
      r_i_rvalid  <= w_i_rvalid;
      r_i_rdata   <= w_i_rdata;
      r_i_err     <= w_i_err;
      r_d_gnt     <= w_d_gnt;
      r_d_rvalid  <= w_d_rvalid;
      r_d_rdata   <= w_d_rdata;
      r_d_err     <= w_d_err;
      r_mem_rd_en <= w_mem_rd_en;
      r_mem_wr_en <= w_mem_wr_en;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

`ifdef BRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fav_i <= 1'b0;
    end else begin
      r_fav_i <= w_fav_i_nxt;
    end
  end
`endif

  assign i_gnt     = r_i_gnt;
  assign i_rvalid  = r_i_rvalid;
  assign i_rdata   = r_i_rdata;
  assign i_err     = r_i_err;
  assign d_gnt     = r_d_gnt;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_wr_en = r_mem_wr_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: directed accesses push expected grants/responses,
// a negedge monitor pops and compares them; a behavioural BRAM sits on the memory port.
module tb_bram_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  bram_arbiter #(.AW(16), .DW(32), .DEPTH(14)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten words read back as 0xC0DE0000 | index.
  bit [31:0] ram     [0:16383];
  bit        ram_wr  [0:16383];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      ram[mem_addr[13:0]]    <= mem_wdata;
      ram_wr[mem_addr[13:0]] <= 1'b1;
    end
    if (mem_rd_en)
      mem_rdata <= ram_wr[mem_addr[13:0]] ? ram[mem_addr[13:0]]
                                          : (32'hC0DE0000 | {18'd0, mem_addr[13:0]});
  end

  typedef struct {
    bit          port;   // 0 = data, 1 = fetch
    int          cyc;    // -1 = do not check timing
    bit          err;
    bit [1:0]    op;     // 0 none, 1 read, 2 write
    logic [15:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          cyc;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t d_q[$];
  rsp_t i_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  gnt_t mg;
  rsp_t mr;

  always @(negedge clk) begin
    if (rst) begin
      if (d_gnt || i_gnt) begin
        if (d_gnt && i_gnt) chk("gnt_both", 128'(1), 128'(0));
        if (gnt_q.size() == 0) begin
          chk("gnt_unexpected", 128'({d_gnt, i_gnt}), 128'(0));
        end else begin
          mg = gnt_q.pop_front();
          chk("gnt_port", 128'(i_gnt), 128'(mg.port));
          if (mg.cyc >= 0) chk("gnt_cycle", 128'(cyc), 128'(mg.cyc));
          chk("gnt_mem_en", 128'({mem_rd_en, mem_wr_en}),
              128'((mg.op == 2'd1) ? 2'b10 : (mg.op == 2'd2) ? 2'b01 : 2'b00));
          chk("gnt_mem_addr", 128'(mem_addr), 128'(mg.addr));
          if (mg.op == 2'd2) chk("gnt_mem_wdata", 128'(mem_wdata), 128'(mg.wdata));
          chk("gnt_d_err", 128'(d_err), 128'(mg.err));
        end
      end else if (mem_rd_en || mem_wr_en || d_err) begin
        chk("mem_en_without_gnt", 128'({mem_rd_en, mem_wr_en, d_err && !d_rvalid}), 128'(0));
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) begin
          chk("d_rvalid_unexpected", 128'(1), 128'(0));
        end else begin
          mr = d_q.pop_front();
          chk("d_rdata", 128'(d_rdata), 128'(mr.data));
          chk("d_rsp_err", 128'(d_err), 128'(mr.err));
          if (mr.cyc >= 0) chk("d_rvalid_cycle", 128'(cyc), 128'(mr.cyc));
        end
      end
      if (i_rvalid) begin
        if (i_q.size() == 0) begin
          chk("i_rvalid_unexpected", 128'(1), 128'(0));
        end else begin
          mr = i_q.pop_front();
          chk("i_rdata", 128'(i_rdata), 128'(mr.data));
          chk("i_rsp_err", 128'(i_err), 128'(mr.err));
          if (mr.cyc >= 0) chk("i_rvalid_cycle", 128'(cyc), 128'(mr.cyc));
        end
      end else if (i_err) begin
        chk("i_err_without_rvalid", 128'(1), 128'(0));
      end
    end
  end

  task automatic access(input bit is_i, input bit we, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
    gnt_t g;
    rsp_t r;
    bit   oor;
    bit   seen;
    int   n;
    oor = (addr[15:14] != 2'b00);
    @(negedge clk);
    n       = cyc;
    g.port  = is_i;
    g.cyc   = n + 1;
    g.err   = !is_i && we && oor;
    g.op    = oor ? 2'd0 : (we ? 2'd2 : 2'd1);
    g.addr  = addr;
    g.wdata = wd;
    gnt_q.push_back(g);
    if (!we) begin
      r.data = oor ? 32'd0 : exp_rd;
      r.err  = oor;
      r.cyc  = n + 3;
      if (is_i) i_q.push_back(r);
      else      d_q.push_back(r);
    end
    if (is_i) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      seen = is_i ? i_gnt : d_gnt;
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if (!seen) chk("gnt_timeout", 128'(seen), 128'(1));
    repeat (3) @(negedge clk);
  endtask

  task automatic contention();
    gnt_t g;
    rsp_t r;
    int   n;
    int   seen;
    @(negedge clk);
    n = cyc;
    for (int k = 0; k < 4; k++) begin
`ifdef BRAM_ARB_RR_EN
      g.port = k[0];
`else
      g.port = 1'b0;
`endif
      g.cyc   = n + 1 + 3 * k;
      g.err   = 1'b0;
      g.op    = 2'd1;
      g.addr  = g.port ? 16'h0200 : 16'h0100;
      g.wdata = 32'd0;
      gnt_q.push_back(g);
      r.data = g.port ? 32'hC0DE0200 : 32'hC0DE0100;
      r.err  = 1'b0;
      r.cyc  = n + 3 + 3 * k;
      if (g.port) i_q.push_back(r);
      else        d_q.push_back(r);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    i_req = 1'b1; i_addr = 16'h0200;
    seen = 0;
    for (int t = 0; t < 40 && seen < 4; t++) begin
      @(negedge clk);
      if (d_gnt || i_gnt) seen++;
    end
    d_req = 1'b0; i_req = 1'b0;
    if (seen != 4) chk("contention_timeout", 128'(seen), 128'(4));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 128'({i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                              mem_rd_en, mem_wr_en, mem_addr, mem_wdata}), 128'(0));
    @(negedge clk);
    rst = 1'b1;

    // Reset asserted while the read of 0x0010 is in ISSUE.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    @(posedge clk);
    #1;
    chk("t1_issue", 128'({d_gnt, mem_rd_en, mem_addr}), 128'({1'b1, 1'b1, 16'h0010}));
    rst = 1'b0;
    #1;
    chk("t1_reset_outputs", 128'({i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                                 mem_rd_en, mem_wr_en, mem_addr, mem_wdata}), 128'(0));
    d_req = 1'b0; d_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single write then read back.
    access(1'b0, 1'b1, 16'h0004, 32'hDEADBEEF, 32'h0);
    access(1'b0, 1'b0, 16'h0004, 32'h0, 32'hDEADBEEF);

    // Fetch read of word 0.
    access(1'b1, 1'b0, 16'h0000, 32'h0, 32'hC0DE0000);

    // Both ports held for four grants.
    contention();

    // Out-of-range write and fetch.
    access(1'b0, 1'b1, 16'h4000, 32'hBAD0BAD0, 32'h0);
    access(1'b1, 1'b0, 16'hFFFF, 32'h0, 32'h0);

    // Top word of the implemented range.
    access(1'b0, 1'b1, 16'h3FFF, 32'h12345678, 32'h0);
    access(1'b0, 1'b0, 16'h3FFF, 32'h0, 32'h12345678);
    access(1'b0, 1'b0, 16'h3FFE, 32'h0, 32'hC0DE3FFE);
    access(1'b0, 1'b0, 16'h0000, 32'h0, 32'hC0DE0000);
    access(1'b1, 1'b0, 16'h3FFF, 32'h0, 32'h12345678);

    repeat (5) @(negedge clk);
    chk("gnt_queue_drained", 128'(gnt_q.size()), 128'(0));
    chk("d_queue_drained", 128'(d_q.size()), 128'(0));
    chk("i_queue_drained", 128'(i_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
